// File: rtl/clk_strobe_gen.sv
// Multi-channel clock-enable generator: per-channel tick strobes and divided levels
// with glitch-free runtime divide updates. Optional mid-period strobe: CLK_STROBE_HALF_EN.
module clk_strobe_gen #(
  parameter int N_CHAN      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 1,
  localparam int CHAN_W     = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CHAN_W-1:0] cfg_chan,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [N_CHAN-1:0] chan_en,
  output logic [N_CHAN-1:0] tick,
  output logic [N_CHAN-1:0] clk_out
`ifdef CLK_STROBE_HALF_EN
  ,
  output logic [N_CHAN-1:0] tick_half
`endif
);

  logic [DIV_W-1:0]  r_cnt      [N_CHAN];
  logic [DIV_W-1:0]  r_div_act  [N_CHAN];
  logic [DIV_W-1:0]  r_div_pend [N_CHAN];
  logic [N_CHAN-1:0] r_pend;
  logic [N_CHAN-1:0] r_tick;
  logic [N_CHAN-1:0] r_clk_out;
  logic [N_CHAN-1:0] r_tick_half;

  logic w_chan_ok;
  logic w_ready;
  logic w_accept;

  // Out-of-range channel numbers are always ready and silently dropped.
  assign w_chan_ok = (32'(cfg_chan) < N_CHAN);

  always_comb begin
    w_ready = 1'b1;
    if (w_chan_ok) w_ready = ~r_pend[cfg_chan];
  end

  assign w_accept  = cfg_valid & w_ready & w_chan_ok;
  assign cfg_ready = w_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        r_cnt[i]      <= '0;
        r_div_act[i]  <= DIV_W'(DEFAULT_DIV);
        r_div_pend[i] <= '0;
      end
      r_pend      <= '0;
      r_tick      <= '0;
      r_clk_out   <= '0;
      r_tick_half <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CHAN; i++) begin
        if (chan_en[i]) begin
          r_tick_half[i] <= (r_cnt[i] == (r_div_act[i] >> 1));
          if (r_cnt[i] == r_div_act[i]) begin
            r_cnt[i]     <= '0;
            r_tick[i]    <= 1'b1;
            r_clk_out[i] <= ~r_clk_out[i];
            if (r_pend[i]) begin
              r_div_act[i] <= r_div_pend[i];
              r_pend[i]    <= 1'b0;
            end
          end else begin
            r_cnt[i]  <= r_cnt[i] + 1'b1;
            r_tick[i] <= 1'b0;
          end
        end else begin
          r_cnt[i]       <= '0;
          r_tick[i]      <= 1'b0;
          r_clk_out[i]   <= 1'b0;
          r_tick_half[i] <= 1'b0;
          if (r_pend[i]) begin
            r_div_act[i] <= r_div_pend[i];
            r_pend[i]    <= 1'b0;
          end
        end
        // Accept only happens while pend is clear, so it never collides with an apply.
        if (w_accept && (32'(cfg_chan) == i)) begin
          r_div_pend[i] <= cfg_div;
          r_pend[i]     <= 1'b1;
        end
      end
    end
  end

  assign tick    = r_tick;
  assign clk_out = r_clk_out;
`ifdef CLK_STROBE_HALF_EN
  assign tick_half = r_tick_half;
`endif

endmodule
